// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Branch-to-self encoding that stops the fetch stream.
  localparam logic [31:0]  HALT_INSTR_DEF = 32'hEAFF_FFFE;
  localparam int unsigned  RESET_PC_DEF   = 0;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_fifo.sv
// Shift-register FIFO of {pc, instr} entries. The head is always entry 0,
// so head data comes straight from a flop.
module instr_fetch_ctrl_fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 39,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [WIDTH-1:0] ent [DEPTH];
  logic [IW-1:0]    wr_idx_c;

  // On a simultaneous pop the write slot moves down with the shift.
  assign wr_idx_c = pop ? IW'(count - CW'(1)) : IW'(count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) ent[i] <= ent[i+1];
      end
      if (push) ent[wr_idx_c] <= push_data;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = ent[0];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues word reads to a 1-cycle synchronous
// instruction memory and buffers returned words for decode.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned             ADDR_NUM    = 128,
  parameter int unsigned             ADDR_WIDTH  = $clog2(ADDR_NUM),
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter int unsigned             FIFO_DEPTH  = 2,
  parameter int unsigned             RESET_PC    = RESET_PC_DEF,
  parameter logic [INSTR_WIDTH-1:0]  HALT_INSTR  = INSTR_WIDTH'(HALT_INSTR_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_en,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   halted,
  output logic                   busy
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;
  localparam int unsigned EW = ADDR_WIDTH + INSTR_WIDTH;

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] tag;
  logic                  inflight;

  logic                  pop_c, push_c, halt_hit_c, issue_c;
  logic [OW-1:0]         occ_c;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty;
  logic [EW-1:0]         fifo_head;

  function automatic logic [ADDR_WIDTH-1:0] pc_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(ADDR_NUM - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  // Handshake, capture and issue decisions; redirect overrides FIFO credit.
  always_comb begin
    pop_c      = instr_valid & instr_ready & ~redirect_valid;
    push_c     = inflight & ~redirect_valid;
    halt_hit_c = push_c & (mem_rdata == HALT_INSTR);
    occ_c      = OW'(fifo_count) + OW'(inflight) - OW'(pop_c);
    issue_c    = (state == RUN) & (occ_c < OW'(FIFO_DEPTH));
    mem_rd_en  = redirect_valid ? fetch_en : issue_c;
    mem_addr   = redirect_valid ? redirect_addr : pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= ADDR_WIDTH'(RESET_PC);
      tag      <= '0;
      inflight <= 1'b0;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      halted <= 1'b0;
      tag    <= redirect_addr;
      if (fetch_en) begin
        state    <= RUN;
        pc       <= pc_inc(redirect_addr);
        inflight <= 1'b1;
      end else begin
        state    <= IDLE;
        pc       <= redirect_addr;
        inflight <= 1'b0;
      end
    end else begin
      // A read issued alongside a halt capture is dropped on return.
      inflight <= issue_c & ~halt_hit_c;
      if (issue_c) begin
        pc  <= pc_inc(pc);
        tag <= pc;
      end
      if (halt_hit_c) begin
        state  <= HALTED;
        halted <= 1'b1;
      end else begin
        case (state)
          IDLE:    if (fetch_en) state <= RUN;
          RUN:     if (!fetch_en) state <= IDLE;
          HALTED:  state <= HALTED;
          default: state <= IDLE;
        endcase
      end
    end
  end

  instr_fetch_ctrl_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW),
    .CW    (CW)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_c),
    .push_data ({tag, mem_rdata}),
    .pop       (pop_c),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_head[INSTR_WIDTH-1:0];
  assign instr_pc    = fifo_head[EW-1:INSTR_WIDTH];
  assign busy        = (state == RUN) | inflight | ~fifo_empty;

  // Credit accounting keeps a capture from landing on a full FIFO.
  assert property (@(posedge clk) disable iff (rst) !(push_c && fifo_full && !pop_c));

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboard bench for instr_fetch_ctrl with a 1-cycle synchronous memory model.
module tb_instr_fetch_ctrl;

  localparam int unsigned AN = 128;
  localparam int unsigned AW = 7;
  localparam logic [31:0] HALT_W = 32'hEAFF_FFFE;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   word;
  } sb_entry_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_en = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          halted;
  logic          busy;

  logic [31:0]   mem [AN];
  sb_entry_t     q[$];
  sb_entry_t     mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  int            lat;

  instr_fetch_ctrl #(.ADDR_NUM(AN), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_run(input int start, input int n);
    sb_entry_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = AW'((start + i) % AN);
      e.word = mem[(start + i) % AN];
      q.push_back(e);
    end
  endtask

  // Cycles until the head shows pc tgt; first sampled negedge is numbered n0.
  task automatic wait_head(input logic [AW-1:0] tgt, input int n0, output int n);
    n = n0;
    @(negedge clk);
    while (!(instr_valid && instr_pc == tgt) && n < n0 + 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_q(input int limit);
    int c = 0;
    while (q.size() > limit && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("wait_q_bound", 64'(q.size() <= limit), 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted head must match the next expected word.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect_valid) begin
      check("sb_expected", 64'(q.size() != 0), 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("instr_pc", 64'(instr_pc), 64'(mon_e.pc));
        check("instr", 64'(instr), 64'(mon_e.word));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    mem[0] = 32'hE3A0_0000;
    mem[1] = 32'hE1A0_100F;
    for (int i = 2; i < AN; i++) mem[i] = 32'hE280_0000 | 32'(i * 37);
    mem[47] = HALT_W;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr_valid", 64'(instr_valid), 0);
    check("rst_instr", 64'(instr), 0);
    check("rst_instr_pc", 64'(instr_pc), 0);
    check("rst_halted", 64'(halted), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_mem_rd_en", 64'(mem_rd_en), 0);
    check("rst_mem_addr", 64'(mem_addr), 0);
    rst = 1'b0;

    // Start stream from RESET_PC: first valid three cycles after fetch_en
    step();
    push_run(0, 31);
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    wait_head(0, 0, lat);
    check("start_latency", 64'(lat), 3);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stream_no_bubble", 64'(instr_valid), 1);
    end

    // Backpressure: FIFO fills and issue stops
    step();
    instr_ready = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_valid", 64'(instr_valid), 1);
    check("stall_no_issue", 64'(mem_rd_en), 0);
    step();
    instr_ready = 1'b1;
    repeat (4) step();

    // Redirect to 40 with a full FIFO; coincident handshake is discarded
    instr_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_addr  = AW'(40);
    instr_ready    = 1'b1;
    q.delete();
    push_run(40, 8);
    @(negedge clk);
    check("redir_rd_en", 64'(mem_rd_en), 1);
    check("redir_addr", 64'(mem_addr), 40);
    step();
    redirect_valid = 1'b0;
    wait_head(AW'(40), 1, lat);
    check("redir_latency", 64'(lat), 2);

    // Halt at 47: delivered, then nothing more is issued
    lat = 0;
    while (!halted && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("halted_set", 64'(halted), 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("halt_no_issue", 64'(mem_rd_en), 0);
    end
    check("halt_drained", 64'(q.size()), 0);
    check("halt_busy", 64'(busy), 0);
    check("halt_hold", 64'(halted), 1);

    // Redirect out of HALTED to 0
    step();
    redirect_valid = 1'b1;
    redirect_addr  = '0;
    push_run(0, 21);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("halt_cleared", 64'(halted), 0);
    wait_head(0, 2, lat);
    check("resume_latency", 64'(lat), 2);
    wait_q(14);

    // PC wrap 127 -> 0
    step();
    redirect_valid = 1'b1;
    redirect_addr  = AW'(120);
    q.delete();
    push_run(120, 24);
    step();
    redirect_valid = 1'b0;
    wait_head(AW'(120), 1, lat);
    check("wrap_latency", 64'(lat), 2);
    wait_q(12);

    // Redirect with fetch_en low: no issue, fetch later starts at target
    step();
    fetch_en       = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = AW'(10);
    q.delete();
    push_run(10, 16);
    @(negedge clk);
    check("redir_idle_no_issue", 64'(mem_rd_en), 0);
    step();
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    wait_head(AW'(10), 0, lat);
    check("idle_redir_latency", 64'(lat), 3);
    wait_q(10);

    // Reset mid-stream with a read in flight
    step();
    rst = 1'b1;
    #1;
    check("midrst_instr_valid", 64'(instr_valid), 0);
    check("midrst_instr", 64'(instr), 0);
    check("midrst_instr_pc", 64'(instr_pc), 0);
    check("midrst_halted", 64'(halted), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_mem_rd_en", 64'(mem_rd_en), 0);
    q.delete();
    push_run(0, 11);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_head(0, 0, lat);
    check("postrst_latency", 64'(lat), 3);
    wait_q(6);

    // Stop fetch and drain
    step();
    fetch_en = 1'b0;
    lat = 0;
    while (busy && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("drain_busy", 64'(busy), 0);
    check("drain_rd_en", 64'(mem_rd_en), 0);
    check("drain_halted", 64'(halted), 0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
